run_length_detector: RTL and testbench
======================================

# run_length_detector

Parametrised Moore-style run-length detector. It samples a serial input `w` on enabled clock edges and flags when the last `RUN_LEN` samples were identical. Run length, value filtering and overlap behaviour are configurable. It also reports the current run length, the run's value, a one-cycle detection pulse and a saturating detection-event count. It sits between debounced switch/key inputs and LED/status logic in the lab designs.

## Interface
- `RUN_LEN`, default 4: consecutive equal samples required for detection; legal range 2 to 255.
- `CNT_W`, default `$clog2(RUN_LEN+1)`: width of `run_cnt`.
- `HIT_W`, default 8: width of `hit_cnt`.
- `OVERLAP`, default 1: 1 means `z` stays high while the run continues; 0 means the run restarts after each detection.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `en`  in  1  sample enable; when low, all state holds.
- `w`  in  1  serial data sample.
- `mode`  in  2  values: 00 detect both values; 01 zeros only; 10 ones only; 11 detection off (counting continues).
- `clr_hits`  in  1  synchronous clear of `hit_cnt`.
- `z`  out  1  detection level (registered).
- `z_pulse`  out  1  one-cycle pulse on each new detection.
- `run_val`  out  1  value of the current run.
- `run_cnt`  out  `CNT_W`  length of the current run, saturating at `RUN_LEN`.
- `hit_cnt`  out  `HIT_W`  detection events since reset or clear, saturating at all-ones.

## Operation
- Two-state FSM.
  - IDLE: no sample taken since reset.
  - RUN: a run is in progress.
- IDLE with `en`=1 → RUN, with `run_val`=w and `run_cnt`=1.
- RUN with `en`=1 and w≠`run_val` → `run_val`=w, `run_cnt`=1.
- RUN with `en`=1 and w=`run_val`:
  - If `run_cnt` < `RUN_LEN`, increment `run_cnt`.
  - If `run_cnt` = `RUN_LEN` and OVERLAP=1, hold at `RUN_LEN`.
  - If `run_cnt` = `RUN_LEN` and OVERLAP=0, set `run_cnt`=1.
- `en`=0: no state change, and `z_pulse`=0.
- `z` = (`run_cnt` == `RUN_LEN`) AND `mode` permits `run_val`. It is a function of registered state only; no combinational path from `w`.
- `z_pulse` is registered. It is 1 for exactly one cycle after the edge on which `run_cnt` becomes `RUN_LEN` (from `RUN_LEN`-1, or from 1 when `RUN_LEN`… N/A) and `mode` permits that value.
- With OVERLAP=0, every `RUN_LEN` equal samples produce one `z_pulse`.
- `hit_cnt` increments on the same edge that sets `z_pulse`. It saturates at 2^`HIT_W`-1.
- `clr_hits` has priority over an increment on the same edge (result 0).
- A `mode` change affects `z` combinationally from registered state. A `mode` change never creates a `z_pulse` by itself.
- `mode`=11: `z`, `z_pulse` and `hit_cnt` increments are suppressed; the run tracker continues.

## Timing
- `Reset`=1 at an edge sets:
  - state=IDLE
  - `run_cnt`=0
  - `run_val`=0
  - `z`=0
  - `z_pulse`=0
  - `hit_cnt`=0
- `Reset` overrides `en`, `clr_hits` and everything else, including mid-run.
- Latency: `z` rises one clock after the edge that samples the `RUN_LEN`-th equal bit (Moore output).
- `z` falls one clock after the edge that samples a differing bit.
- `run_val` and `run_cnt` update on the sampling edge and are visible the following cycle.
- Alternating input never produces `z`, for any `RUN_LEN` ≥ 2.

## Structure
- Package `run_det_pkg` holds:
  - mode constants `MODE_BOTH`, `MODE_ZEROS`, `MODE_ONES`, `MODE_OFF`
  - the FSM state enum (`ST_IDLE`, `ST_RUN`)
- Sub-module `sat_counter` (parameter `W`; ports `Clock`, `Reset`, `clr`, `inc`, `q`) implements the saturating `hit_cnt`.
- The run tracker is inline in the top module.

## Test plan
- Reset, then w=0 on 4 enabled edges (RUN_LEN=4, mode=00) → `z`=1 after the 4th edge; `z_pulse` high one cycle; `hit_cnt`=1; `run_cnt`=4.
- Continue w=0 for 3 more edges (OVERLAP=1) → `z` stays 1, no further pulse, `hit_cnt`=1. Then w=1 → `z`=0, `run_val`=1, `run_cnt`=1.
- OVERLAP=0, w=1 for 8 edges → two `z_pulse`s, after the 4th and 8th edges; `hit_cnt`=2.
- mode=10 with w=0×4 → `z`=0, `hit_cnt` unchanged. Switch to mode=00 with `run_cnt`=4 → `z`=1 next cycle, no `z_pulse`.
- `en` toggled low between samples, w=1,1,1,1 only on `en`=1 edges → detection after the 4th enabled sample. Assert `Reset` mid-run at `run_cnt`=3 → all outputs 0 next cycle.
- HIT_W=2, five OVERLAP=0 detections → `hit_cnt` saturates at 3. `clr_hits` asserted on the same edge as a detection → `hit_cnt`=0.

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// -----------------------------------------------------------------------------
// run_det_pkg
// Shared definitions for the run-length detector:
//   - mode encodings (which run values may raise a detection)
//   - the run-tracker FSM state type
//   - mode_permits(): decides whether a run of a given value may be reported
// -----------------------------------------------------------------------------
package run_det_pkg;

    localparam logic [1:0] MODE_BOTH  = 2'b00;
    localparam logic [1:0] MODE_ZEROS = 2'b01;
    localparam logic [1:0] MODE_ONES  = 2'b10;
    localparam logic [1:0] MODE_OFF   = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // True when a run of value 'val' is allowed to be reported under 'mode'.
    function automatic logic mode_permits(input logic [1:0] mode, input logic val);
        logic ok;
        case (mode)
            MODE_BOTH:  ok = 1'b1;
            MODE_ZEROS: ok = ~val;
            MODE_ONES:  ok = val;
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/run_length_detector_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   Clock : rising-edge clock
//   Reset : synchronous active-high reset (clears the count)
//   clr   : synchronous clear, wins over inc
//   inc   : count one event (ignored once all-ones is reached)
//   q     : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear first, otherwise increment until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
// Flags when the last RUN_LEN enabled samples of 'w' were identical.
//   Clock    : rising-edge clock
//   Reset    : synchronous active-high reset
//   en       : sample enable; all state holds while low
//   w        : serial data sample
//   mode     : 00 both values, 01 zeros only, 10 ones only, 11 detection off
//   clr_hits : synchronous clear of hit_cnt
//   z        : detection level, derived from registered state only
//   z_pulse  : one-cycle pulse on each new detection
//   run_val  : value of the current run
//   run_cnt  : current run length, saturating at RUN_LEN
//   hit_cnt  : saturating count of detection events
// -----------------------------------------------------------------------------
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = $clog2(RUN_LEN + 1),
    parameter int HIT_W   = 8,
    parameter int OVERLAP = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    input  logic             clr_hits,
    output logic             z,
    output logic             z_pulse,
    output logic             run_val,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HIT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RUN_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q;
    state_e           state_d;
    logic             run_val_q;
    logic             run_val_d;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_cnt_d;
    logic             z_pulse_q;
    logic             z_pulse_d;
    logic             reach_s;

    // Run tracker next state; reach_s marks the edge on which the count
    // climbs to RUN_LEN, which is the only moment a new detection occurs.
    always_comb begin
        state_d   = state_q;
        run_val_d = run_val_q;
        run_cnt_d = run_cnt_q;
        reach_s   = 1'b0;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RUN;
                    run_val_d = w;
                    run_cnt_d = CNT_ONE;
                end
                ST_RUN: begin
                    if (w != run_val_q) begin
                        run_val_d = w;
                        run_cnt_d = CNT_ONE;
                    end else if (run_cnt_q < CNT_MAX) begin
                        run_cnt_d = run_cnt_q + CNT_ONE;
                        reach_s   = ((run_cnt_q + CNT_ONE) == CNT_MAX);
                    end else if (OVERLAP != 0) begin
                        run_cnt_d = CNT_MAX;
                    end else begin
                        // Non-overlapping: the next run starts with this sample.
                        run_cnt_d = CNT_ONE;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    run_val_d = 1'b0;
                    run_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end else begin
            state_d = state_q;
        end
        // Pulse only on a sampling edge, so a later mode change cannot create one.
        z_pulse_d = reach_s & mode_permits(mode, w);
    end

    // Tracker and pulse registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            run_val_q <= 1'b0;
            run_cnt_q <= {CNT_W{1'b0}};
            z_pulse_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_val_q <= run_val_d;
            run_cnt_q <= run_cnt_d;
            z_pulse_q <= z_pulse_d;
        end
    end

    sat_counter #(
        .W (HIT_W)
    ) u_hits (
        .Clock (Clock),
        .Reset (Reset),
        .clr   (clr_hits),
        .inc   (z_pulse_d),
        .q     (hit_cnt)
    );

    // Level follows registered run state; mode gates it without a path from w.
    assign z       = (run_cnt_q == CNT_MAX) && mode_permits(mode, run_val_q);
    assign z_pulse = z_pulse_q;
    assign run_val = run_val_q;
    assign run_cnt = run_cnt_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: two instances share the inputs, one with
// overlapping detection (HIT_W=8) and one non-overlapping (HIT_W=2). Expected
// values come from a model that tracks the length of the trailing run of
// equal enabled samples as a plain integer.
module tb_run_length_detector;

    localparam int RL = 4;

    logic       Clock;
    logic       Reset;
    logic       en;
    logic       w;
    logic [1:0] mode;
    logic       clr_hits;

    logic       z_a, zp_a, rv_a;
    logic [2:0] rc_a;
    logic [7:0] hc_a;
    logic       z_b, zp_b, rv_b;
    logic [2:0] rc_b;
    logic [1:0] hc_b;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    // reference model state
    int   trail;
    logic mval;
    int   hits_a;
    int   hits_b;
    logic pa;
    logic pb;

    run_length_detector #(.RUN_LEN(RL), .HIT_W(8), .OVERLAP(1)) dut_a (
        .Clock(Clock), .Reset(Reset), .en(en), .w(w), .mode(mode),
        .clr_hits(clr_hits), .z(z_a), .z_pulse(zp_a), .run_val(rv_a),
        .run_cnt(rc_a), .hit_cnt(hc_a)
    );

    run_length_detector #(.RUN_LEN(RL), .HIT_W(2), .OVERLAP(0)) dut_b (
        .Clock(Clock), .Reset(Reset), .en(en), .w(w), .mode(mode),
        .clr_hits(clr_hits), .z(z_b), .z_pulse(zp_b), .run_val(rv_b),
        .run_cnt(rc_b), .hit_cnt(hc_b)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic allowed(input logic [1:0] m, input logic v);
        return (m == 2'd0) || (m == 2'd1 && v == 1'b0) || (m == 2'd2 && v == 1'b1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one clock with the given inputs, advance the model, compare both DUTs.
    task automatic step(input logic e, input logic wi, input logic [1:0] m,
                        input logic c, input logic r);
        int cnt_a;
        int cnt_b;
        en = e; w = wi; mode = m; clr_hits = c; Reset = r;
        @(posedge Clock);
        pa = 1'b0;
        pb = 1'b0;
        if (r) begin
            trail = 0; mval = 1'b0; hits_a = 0; hits_b = 0;
        end else begin
            if (e) begin
                if (trail == 0 || wi != mval) begin
                    trail = 1;
                    mval  = wi;
                end else begin
                    trail++;
                end
                if (allowed(m, wi)) begin
                    pa = (trail == RL);
                    pb = ((trail % RL) == 0);
                end
            end
            if (c) hits_a = 0; else if (pa && hits_a < 255) hits_a++;
            if (c) hits_b = 0; else if (pb && hits_b < 3) hits_b++;
        end
        cnt_a = (trail == 0) ? 0 : ((trail > RL) ? RL : trail);
        cnt_b = (trail == 0) ? 0 : (((trail - 1) % RL) + 1);
        #1;
        check("a_z",       int'(z_a),  int'(cnt_a == RL && allowed(m, mval)));
        check("a_z_pulse", int'(zp_a), int'(pa));
        check("a_run_val", int'(rv_a), int'(mval));
        check("a_run_cnt", int'(rc_a), cnt_a);
        check("a_hit_cnt", int'(hc_a), hits_a);
        check("b_z",       int'(z_b),  int'(cnt_b == RL && allowed(m, mval)));
        check("b_z_pulse", int'(zp_b), int'(pb));
        check("b_run_val", int'(rv_b), int'(mval));
        check("b_run_cnt", int'(rc_b), cnt_b);
        check("b_hit_cnt", int'(hc_b), hits_b);
    endtask

    initial begin
        logic       rw;
        logic [1:0] rm;
        Reset = 1'b1; en = 1'b0; w = 1'b0; mode = 2'd0; clr_hits = 1'b0;
        trail = 0; mval = 1'b0; hits_a = 0; hits_b = 0; pa = 1'b0; pb = 1'b0;

        // reset state
        step(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        check("rst_run_cnt", int'(rc_a), 0);
        check("rst_z", int'(z_a), 0);

        // four zeros -> detection, then overlap continuation
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("tp1_z", int'(z_a), 1);
        check("tp1_pulse", int'(zp_a), 1);
        check("tp1_hits", int'(hc_a), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        check("tp2_hits", int'(hc_a), 1);
        step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        check("tp2_z_fall", int'(z_a), 0);
        check("tp2_run_cnt", int'(rc_a), 1);

        // non-overlapping: 8 ones -> two pulses
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        check("tp3_hits_b", int'(hc_b), 2);

        // mode filtering and mode change without pulse
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
        check("tp4_z_off", int'(z_a), 0);
        step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        check("tp4_z_on", int'(z_a), 1);
        check("tp4_no_pulse", int'(zp_a), 0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'd3, 1'b0, 1'b0);

        // enable gaps, then reset mid-run
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
            step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        end
        check("tp5_z", int'(z_a), 1);
        step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        check("tp5_rst_cnt", int'(rc_a), 0);

        // saturation of the 2-bit counter, clear beating a detection
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        check("tp6_sat", int'(hc_b), 3);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        check("tp6_clr_pulse", int'(zp_b), 1);
        check("tp6_clr", int'(hc_b), 0);

        // alternating input never detects
        for (int i = 0; i < 12; i++) step(1'b1, i[0], 2'd0, 1'b0, 1'b0);
        check("alt_z", int'(z_a | z_b), 0);

        // randomized sticky stimulus
        rw = 1'b0;
        rm = 2'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 3) rw = ~rw;
            if ($urandom_range(0, 15) == 0) rm = 2'($urandom_range(0, 3));
            step(1'($urandom_range(0, 3) != 0), rw, rm,
                 1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
